// File: rtl/mmio_parallel_port_if.sv
// Bus bundle between the core's data-address path and the parallel port:
// address and store data in, the load data and RAM write strobe out, plus
// the external channel pins and the interrupt line.
interface mmio_parallel_port_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int N_OUT  = 2,
  parameter int N_IN   = 2
);
  logic [ADDR_W-1:0]       address;
  logic [DATA_W-1:0]       wr_data;
  logic                    we;
  logic [DATA_W-1:0]       mem_rdata;
  logic [N_IN*DATA_W-1:0]  io_in;
  logic                    mem_we;
  logic [DATA_W-1:0]       rd_data;
  logic [N_OUT*DATA_W-1:0] io_out;
  logic                    irq;

  modport slave (
    input  address, wr_data, we, mem_rdata, io_in,
    output mem_we, rd_data, io_out, irq
  );

  modport master (
    output address, wr_data, we, mem_rdata, io_in,
    input  mem_we, rd_data, io_out, irq
  );
endinterface

// File: rtl/mmio_parallel_port.sv
// Memory-mapped parallel port. A 16-word window at BASE holds the output
// channel registers, the synchronised input channels, a change STATUS
// register (write-1-to-clear) and an interrupt MASK. Every other address
// passes straight through to the data RAM.
module mmio_parallel_port #(
  parameter int              DATA_W = 8,
  parameter int              ADDR_W = 8,
  parameter int              N_OUT  = 2,
  parameter int              N_IN   = 2,
  parameter logic [ADDR_W-1:0] BASE = 8'hF0
) (
  input  logic                 clk,
  input  logic                 rst,
  mmio_parallel_port_if.slave  bus
);

  logic                   in_win;
  logic [3:0]             off;
  logic                   wr_win;
  logic [DATA_W-1:0]      out_q [N_OUT];
  logic [N_IN*DATA_W-1:0] sync1;
  logic [N_IN*DATA_W-1:0] sync2;
  logic [N_IN*DATA_W-1:0] prev;
  logic [N_IN-1:0]        status;
  logic [N_IN-1:0]        mask;
  logic [N_IN-1:0]        chg;
  logic [N_IN-1:0]        clr;
  logic [1:0]             cnt;
  logic                   armed;
  logic [DATA_W-1:0]      rd_win;

  assign in_win = (bus.address[ADDR_W-1:4] == BASE[ADDR_W-1:4]);
  assign off    = bus.address[3:0];
  assign wr_win = bus.we & in_win;

  // Output channel registers; offsets at or above N_OUT have no storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_OUT; i++) out_q[i] <= '0;
    end else if (wr_win && !off[3]) begin
      for (int i = 0; i < N_OUT; i++)
        if (off[2:0] == 3'(i)) out_q[i] <= bus.wr_data;
    end
  end

  for (genvar g = 0; g < N_OUT; g++) begin : g_out
    assign bus.io_out[g*DATA_W +: DATA_W] = out_q[g];
  end

  // Two-flop synchroniser plus one history stage for change detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= bus.io_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  for (genvar g = 0; g < N_IN; g++) begin : g_chg
    assign chg[g] = (sync2[g*DATA_W +: DATA_W] != prev[g*DATA_W +: DATA_W]);
  end

  // Warm-up counter: the synchronisers start from zero after reset, so the
  // first real input value would look like a change until prev catches up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               cnt <= 2'd0;
    else if (cnt != 2'd3)  cnt <= cnt + 2'd1;
  end

  assign armed = (cnt == 2'd3);
  assign clr   = (wr_win && off == 4'd12) ? bus.wr_data[N_IN-1:0] : '0;

  // STATUS: sticky change flags; a new change beats a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) status <= '0;
    else     status <= (status & ~clr) | (chg & {N_IN{armed}});
  end

  // Interrupt mask register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          mask <= '0;
    else if (wr_win && off == 4'd13)  mask <= bus.wr_data[N_IN-1:0];
  end

  // Window read map, combinational from current register state.
  always_comb begin
    rd_win = '0;
    if (!off[3]) begin
      for (int i = 0; i < N_OUT; i++)
        if (off[2:0] == 3'(i)) rd_win = out_q[i];
    end else if (off[3:2] == 2'b10) begin
      for (int i = 0; i < N_IN; i++)
        if (off[1:0] == 2'(i)) rd_win = sync2[i*DATA_W +: DATA_W];
    end else if (off == 4'd12) begin
      rd_win[N_IN-1:0] = status;
    end else if (off == 4'd13) begin
      rd_win[N_IN-1:0] = mask;
    end
  end

  assign bus.mem_we  = bus.we & ~in_win;
  assign bus.rd_data = in_win ? rd_win : bus.mem_rdata;
  assign bus.irq     = |(status & mask);

endmodule

// File: tb/tb_mmio_parallel_port.sv
// Testbench for mmio_parallel_port: stimulus pushes expected outputs into a
// scoreboard queue tagged with the cycle they belong to; a monitor on the
// falling edge pops and compares them against the DUT.
module tb_mmio_parallel_port;

  localparam int K_RD = 0, K_MEMWE = 1, K_IOOUT = 2, K_IRQ = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mmio_parallel_port_if #(.DATA_W(8), .ADDR_W(8), .N_OUT(2), .N_IN(2)) bus ();

  mmio_parallel_port #(
    .DATA_W(8), .ADDR_W(8), .N_OUT(2), .N_IN(2), .BASE(8'hF0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] exp;
    string       nm;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  logic [31:0] mon_act;

  // Reference model: register contents plus the full history of io_in as
  // seen at each clock edge since reset release.
  logic [7:0]  m_out [2];
  logic [1:0]  m_status;
  logic [1:0]  m_mask;
  logic [15:0] hist[$];
  int          m_n;
  logic [15:0] io_cur;

  function automatic logic [15:0] h(int k);
    if (k >= 1 && k <= hist.size()) return hist[k-1];
    return 16'h0000;
  endfunction

  task automatic model_reset();
    m_out[0] = 8'h00;
    m_out[1] = 8'h00;
    m_status = 2'b00;
    m_mask   = 2'b00;
    hist.delete();
    m_n = 0;
  endtask

  // Edge n: input sampled at edge j shows on IN after edge j+1; a change is
  // flagged when the values visible before edge n (from edges n-2 and n-3)
  // differ, but only once three edges have passed since release.
  task automatic model_edge();
    logic [15:0] a, b;
    logic [1:0]  chg, clr;
    logic [3:0]  off;
    if (rst) return;
    m_n++;
    chg = 2'b00;
    clr = 2'b00;
    a = h(m_n - 2);
    b = h(m_n - 3);
    if (m_n >= 4)
      for (int c = 0; c < 2; c++)
        if (a[c*8 +: 8] != b[c*8 +: 8]) chg[c] = 1'b1;
    off = bus.address[3:0];
    if (bus.we && bus.address[7:4] == 4'hF) begin
      if (off < 4'd2)        m_out[off[0]] = bus.wr_data;
      else if (off == 4'd12) clr = bus.wr_data[1:0];
      else if (off == 4'd13) m_mask = bus.wr_data[1:0];
    end
    m_status = (m_status & ~clr) | chg;
    hist.push_back(bus.io_in);
  endtask

  function automatic logic [7:0] exp_rd(logic [7:0] addr, logic [7:0] mrd);
    logic [15:0] s;
    logic [3:0]  off;
    off = addr[3:0];
    if (addr[7:4] != 4'hF) return mrd;
    if (off < 4'd2) return m_out[off[0]];
    if (off < 4'd8) return 8'h00;
    s = h(m_n - 1);
    if (off == 4'd8)  return s[7:0];
    if (off == 4'd9)  return s[15:8];
    if (off == 4'd12) return {6'b0, m_status};
    if (off == 4'd13) return {6'b0, m_mask};
    return 8'h00;
  endfunction

  task automatic push(int kind, logic [31:0] e, string nm);
    exp_t x;
    x.cyc  = cyc;
    x.kind = kind;
    x.exp  = e;
    x.nm   = nm;
    sb_q.push_back(x);
  endtask

  task automatic push_all();
    push(K_RD, 32'(exp_rd(bus.address, bus.mem_rdata)), "rd_data");
    push(K_MEMWE, 32'(bus.we && bus.address[7:4] != 4'hF), "mem_we");
    push(K_IOOUT, 32'({m_out[1], m_out[0]}), "io_out");
    push(K_IRQ, 32'(|(m_status & m_mask)), "irq");
  endtask

  task automatic drive(logic [7:0] addr, logic [7:0] wd, logic w, logic [7:0] mrd);
    bus.address   = addr;
    bus.wr_data   = wd;
    bus.we        = w;
    bus.mem_rdata = mrd;
    bus.io_in     = io_cur;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cycle(logic [7:0] addr, logic [7:0] wd, logic w, logic [7:0] mrd);
    drive(addr, wd, w, mrd);
    push_all();
    step();
  endtask

  // Monitor: compare every expectation due in this cycle on the falling edge.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      mon_e = sb_q.pop_front();
      case (mon_e.kind)
        K_RD:    mon_act = 32'(bus.rd_data);
        K_MEMWE: mon_act = 32'(bus.mem_we);
        K_IOOUT: mon_act = 32'(bus.io_out);
        default: mon_act = 32'(bus.irq);
      endcase
      n_cmp++;
      if (mon_act !== mon_e.exp) begin
        n_bad++;
        $display("FAIL %s cyc=%0d got=%0h want=%0h", mon_e.nm, mon_e.cyc, mon_act, mon_e.exp);
      end
    end
  end

  initial begin
    io_cur = 16'hA53C;
    rst = 1'b1;
    model_reset();
    drive(8'h00, 8'h00, 1'b0, 8'h00);
    @(posedge clk);
    #1;

    // Reset state
    drive(8'hFC, 8'h00, 1'b0, 8'h00);
    push_all();
    push(K_IOOUT, 32'h0, "rst_io_out");
    push(K_IRQ, 32'h0, "rst_irq");
    step();

    // Release; inputs already stable, warm-up must hide the startup change
    drive(8'hFC, 8'h00, 1'b0, 8'h00);
    rst = 1'b0;
    push_all();
    step();
    for (int i = 0; i < 4; i++) cycle(8'hFC, 8'h00, 1'b0, 8'h00);
    drive(8'hFC, 8'h00, 1'b0, 8'h00);
    push_all();
    push(K_RD, 32'h0, "status_after_warmup");
    step();
    drive(8'hF8, 8'h00, 1'b0, 8'h00);
    push_all();
    push(K_RD, 32'h3C, "in0");
    step();
    drive(8'hF9, 8'h00, 1'b0, 8'h00);
    push_all();
    push(K_RD, 32'hA5, "in1");
    step();

    // Window store, pass-through store and load
    drive(8'hF0, 8'h5A, 1'b1, 8'h00);
    push_all();
    push(K_MEMWE, 32'h0, "win_store_mem_we");
    step();
    drive(8'h20, 8'h5A, 1'b1, 8'h00);
    push_all();
    push(K_IOOUT, 32'h005A, "out0_written");
    push(K_MEMWE, 32'h1, "ram_store_mem_we");
    step();
    drive(8'h20, 8'h00, 1'b0, 8'h77);
    push_all();
    push(K_RD, 32'h77, "ram_load");
    push(K_IOOUT, 32'h005A, "out_unchanged");
    step();

    // Change detect, mask and write-1-to-clear
    cycle(8'hFD, 8'h01, 1'b1, 8'h00);
    io_cur = 16'hA53D;
    for (int i = 0; i < 3; i++) cycle(8'hFC, 8'h00, 1'b0, 8'h00);
    drive(8'hFC, 8'h00, 1'b0, 8'h00);
    push_all();
    push(K_RD, 32'h01, "status_set");
    push(K_IRQ, 32'h1, "irq_set");
    step();
    cycle(8'hFC, 8'h01, 1'b1, 8'h00);
    drive(8'hFC, 8'h00, 1'b0, 8'h00);
    push_all();
    push(K_RD, 32'h00, "status_cleared");
    push(K_IRQ, 32'h0, "irq_cleared");
    step();

    // Clear in the same cycle a new change lands: set wins
    io_cur = 16'hA53C;
    for (int i = 0; i < 2; i++) cycle(8'hFC, 8'h00, 1'b0, 8'h00);
    cycle(8'hFC, 8'h01, 1'b1, 8'h00);
    drive(8'hFC, 8'h00, 1'b0, 8'h00);
    push_all();
    push(K_RD, 32'h01, "set_beats_clear");
    step();
    cycle(8'hFC, 8'h01, 1'b1, 8'h00);

    // Unmapped / missing registers
    drive(8'hF5, 8'hAA, 1'b1, 8'h00);
    push_all();
    push(K_MEMWE, 32'h0, "unmapped_mem_we");
    step();
    cycle(8'hFE, 8'hAA, 1'b1, 8'h00);
    drive(8'hF5, 8'h00, 1'b0, 8'h99);
    push_all();
    push(K_RD, 32'h0, "rd_f5");
    push(K_IOOUT, 32'h005A, "unmapped_no_change");
    step();
    drive(8'hFA, 8'h00, 1'b0, 8'h99);
    push_all();
    push(K_RD, 32'h0, "rd_fa");
    step();
    drive(8'hFE, 8'h00, 1'b0, 8'h99);
    push_all();
    push(K_RD, 32'h0, "rd_fe");
    step();

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [7:0] a;
      if ($urandom_range(0, 3) == 0) a = 8'($urandom);
      else                           a = {4'hF, 4'($urandom)};
      if ($urandom_range(0, 4) == 0) io_cur = 16'($urandom);
      cycle(a, 8'($urandom), 1'($urandom), 8'($urandom));
    end

    // Asynchronous reset in the middle of a cycle
    cycle(8'hF0, 8'hFF, 1'b1, 8'h00);
    cycle(8'hFD, 8'h03, 1'b1, 8'h00);
    io_cur = io_cur ^ 16'h0101;
    for (int i = 0; i < 3; i++) cycle(8'hFC, 8'h00, 1'b0, 8'h00);
    drive(8'hFC, 8'h00, 1'b0, 8'h00);
    push_all();
    push(K_RD, 32'h03, "status_both");
    push(K_IRQ, 32'h1, "irq_both");
    step();
    drive(8'hFC, 8'h00, 1'b0, 8'h00);
    #2;
    rst = 1'b1;
    model_reset();
    push_all();
    push(K_IOOUT, 32'h0, "midrst_io_out");
    push(K_IRQ, 32'h0, "midrst_irq");
    push(K_RD, 32'h0, "midrst_status");
    step();
    io_cur = 16'h1234;
    cycle(8'hFC, 8'h00, 1'b0, 8'h00);
    io_cur = 16'h4321;
    drive(8'hFC, 8'h00, 1'b0, 8'h00);
    rst = 1'b0;
    push_all();
    step();
    for (int i = 0; i < 5; i++) cycle(8'hFC, 8'h00, 1'b0, 8'h00);
    drive(8'hFC, 8'h00, 1'b0, 8'h00);
    push_all();
    push(K_RD, 32'h0, "warmup_drops_change");
    step();

    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain left=%0d want=0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
